// File: rtl/raw_comb_pkg.sv
// Shared definitions for the raw stream combiner.
//   BUNDLE_W   : width of one SPI bundle word
//   CH_LSB/MSB : position of the channel-ID field inside a bundle word
//   CHIP_CH_W  : bits of the per-chip channel index (32 channels per RHD2132)
//   lane_slice : extracts the channel-ID field from a bundle word
package raw_comb_pkg;

  localparam int BUNDLE_W  = 32;
  localparam int CH_LSB    = 17;
  localparam int CH_MSB    = 28;
  localparam int CH_FLD_W  = CH_MSB - CH_LSB + 1;
  localparam int CHIP_CH_W = 5;

  function automatic logic [CH_FLD_W-1:0] lane_slice(input logic [BUNDLE_W-1:0] bundle);
    return bundle[CH_MSB:CH_LSB];
  endfunction

endpackage

// File: rtl/raw_comb_sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk   : clock
//   flush : synchronous clear of pointers and occupancy (also used as reset)
//   push  : write din; accepted when not full, or when full and popping
//   pop   : consume dout; ignored when empty
//   din   : write data
//   dout  : head word, valid whenever empty=0
//   full  : occupancy == DEPTH
//   empty : occupancy == 0
module sync_fwft_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/raw_comb_nstream.sv
// Combines one-hot-tagged SPI bundle words from NUM_STREAMS Intan streams
// into one wide beat per sample slot.
//   bus_clk     : sole clock
//   reset       : synchronous, active-high
//   stream_en   : per-lane enable; a disabled lane is flushed and outputs zero
//   clr_status  : pulse clearing overflow, misalign and beat_cnt
//   in_streamno : one-hot (or multi-hot broadcast) write strobe per stream
//   in_bundle   : SPI bundle word (data in [DATA_W-1:0], channel in [28:17])
//   out_ready   : downstream ready
//   out_valid   : combined beat valid
//   out_data    : lane k at [k*DATA_W +: DATA_W]
//   out_ch      : lane k at [k*CH_W +: CH_W]
//   overflow    : sticky per-stream write-dropped flag
//   misalign    : sticky chip-channel disagreement flag
//   beat_cnt    : beats accepted downstream (wraps)
module raw_comb_nstream
  import raw_comb_pkg::*;
#(
  parameter int NUM_STREAMS = 5,
  parameter int FIFO_DEPTH  = 16,
  parameter int DATA_W      = 16,
  parameter int CH_W        = 12
) (
  input  logic                          bus_clk,
  input  logic                          reset,
  input  logic [NUM_STREAMS-1:0]        stream_en,
  input  logic                          clr_status,
  input  logic [NUM_STREAMS-1:0]        in_streamno,
  input  logic [BUNDLE_W-1:0]           in_bundle,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [NUM_STREAMS*DATA_W-1:0] out_data,
  output logic [NUM_STREAMS*CH_W-1:0]   out_ch,
  output logic [NUM_STREAMS-1:0]        overflow,
  output logic                          misalign,
  output logic [31:0]                   beat_cnt
);

  logic [NUM_STREAMS-1:0] wr_req;
  logic [NUM_STREAMS-1:0] pop;
  logic [NUM_STREAMS-1:0] full;
  logic [NUM_STREAMS-1:0] empty;
  logic [NUM_STREAMS-1:0] ovf_evt;
  logic [BUNDLE_W-1:0]    dout [NUM_STREAMS];
  logic [CH_FLD_W-1:0]    lane_ch_p0 [NUM_STREAMS];

  logic                          fire_p0;
  logic                          mis_p0;
  logic                          accept;
  logic [NUM_STREAMS*DATA_W-1:0] data_p0;
  logic [NUM_STREAMS*CH_W-1:0]   ch_p0;

  assign wr_req  = in_streamno & stream_en;
  assign pop     = fire_p0 ? stream_en : '0;
  assign ovf_evt = wr_req & full & ~pop;
  assign accept  = out_valid & out_ready;

  for (genvar k = 0; k < NUM_STREAMS; k++) begin : g_lane
    logic unused_lane;

    // Disabled lanes are held flushed so stale words never reappear on re-enable.
    sync_fwft_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (BUNDLE_W)
    ) u_fifo (
      .clk   (bus_clk),
      .flush (reset | ~stream_en[k]),
      .push  (wr_req[k]),
      .pop   (pop[k]),
      .din   (in_bundle),
      .dout  (dout[k]),
      .full  (full[k]),
      .empty (empty[k])
    );

    assign lane_ch_p0[k] = lane_slice(dout[k]);
    assign unused_lane   = ^dout[k];
  end

  // Stage p0: combine decision, lane muxing and alignment check on FIFO heads.
  always_comb begin
    logic                 ref_found;
    logic [CHIP_CH_W-1:0] ref_ch;
    logic                 all_ready;

    all_ready = &(~empty | ~stream_en);
    fire_p0   = (|stream_en) & all_ready & (~out_valid | out_ready);

    data_p0   = '0;
    ch_p0     = '0;
    ref_found = 1'b0;
    ref_ch    = '0;
    mis_p0    = 1'b0;
    for (int k = 0; k < NUM_STREAMS; k++) begin
      if (stream_en[k]) begin
        data_p0[k*DATA_W +: DATA_W] = dout[k][DATA_W-1:0];
        ch_p0[k*CH_W +: CH_W]       = CH_W'(lane_ch_p0[k]);
        // Lowest-indexed enabled lane is the reference chip channel.
        if (!ref_found) begin
          ref_found = 1'b1;
          ref_ch    = lane_ch_p0[k][CHIP_CH_W-1:0];
        end else if (lane_ch_p0[k][CHIP_CH_W-1:0] != ref_ch) begin
          mis_p0 = 1'b1;
        end
      end
    end
  end

  // Stage p1: output register, holds while out_valid and not out_ready.
  always_ff @(posedge bus_clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (fire_p0) begin
      out_valid <= 1'b1;
      out_data  <= data_p0;
      out_ch    <= ch_p0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Status: set/increment events take priority over clr_status.
  always_ff @(posedge bus_clk) begin
    if (reset) begin
      overflow <= '0;
      misalign <= 1'b0;
      beat_cnt <= '0;
    end else begin
      overflow <= (clr_status ? '0 : overflow) | ovf_evt;

      if (fire_p0 && mis_p0) misalign <= 1'b1;
      else if (clr_status)   misalign <= 1'b0;

      if (clr_status)  beat_cnt <= accept ? 32'd1 : 32'd0;
      else if (accept) beat_cnt <= beat_cnt + 32'd1;
    end
  end

endmodule
